// File: rtl/res_station_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : res_station_pkg
//  Brief    : Shared types and constants for the reservation-station bank.
//  Revision : 1.0 - initial release
// ============================================================================
package res_station_pkg;

    typedef logic [1:0] rs_state_t;

    localparam rs_state_t c_st_free  = 2'd0;
    localparam rs_state_t c_st_wait  = 2'd1;
    localparam rs_state_t c_st_ready = 2'd2;
    localparam rs_state_t c_st_exec  = 2'd3;

    localparam int          c_tag_none = 0;
    localparam logic [15:0] c_noval    = 16'hFFF0;

    // Slot record at the default 16-bit data / 3-bit tag / 3-bit opcode widths.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [2:0]  qj;
        logic [2:0]  qk;
        rs_state_t   state;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/res_station_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : res_station_bank_if
//  Brief    : Issue, CDB, dispatch and status signals of the station bank.
//  Revision : 1.0 - initial release
// ============================================================================
interface res_station_bank_if #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 3,
    parameter int ENTRIES = 4
);
    localparam int c_CNT_W = $clog2(ENTRIES + 1);

    logic                Issue_valid;
    logic                Issue_ready;
    logic [OP_W-1:0]     Issue_opcode;
    logic [DATA_W-1:0]   Issue_vj;
    logic [DATA_W-1:0]   Issue_vk;
    logic [TAG_W-1:0]    Issue_qj;
    logic [TAG_W-1:0]    Issue_qk;
    logic [TAG_W-1:0]    Issue_tag;
    logic                Cdb_valid;
    logic [TAG_W-1:0]    Cdb_tag;
    logic [DATA_W-1:0]   Cdb_value;
    logic                Disp_valid;
    logic                Disp_ready;
    logic [OP_W-1:0]     Disp_opcode;
    logic [DATA_W-1:0]   Disp_vj;
    logic [DATA_W-1:0]   Disp_vk;
    logic [TAG_W-1:0]    Disp_tag;
    logic [ENTRIES-1:0]  Busy_vec;
    logic [c_CNT_W-1:0]  Count;

    modport slave (
        input  Issue_valid, Issue_opcode, Issue_vj, Issue_vk, Issue_qj, Issue_qk,
        input  Cdb_valid, Cdb_tag, Cdb_value, Disp_ready,
        output Issue_ready, Issue_tag, Disp_valid, Disp_opcode, Disp_vj, Disp_vk,
        output Disp_tag, Busy_vec, Count
    );

    modport master (
        output Issue_valid, Issue_opcode, Issue_vj, Issue_vk, Issue_qj, Issue_qk,
        output Cdb_valid, Cdb_tag, Cdb_value, Disp_ready,
        input  Issue_ready, Issue_tag, Disp_valid, Disp_opcode, Disp_vj, Disp_vk,
        input  Disp_tag, Busy_vec, Count
    );

endinterface
`default_nettype wire

// File: rtl/res_station_bank_entry.sv
`default_nettype none
// ============================================================================
//  Module   : rs_entry
//  Brief    : One reservation slot: FREE/WAIT/READY/EXEC FSM with CDB capture.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_entry
    import res_station_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter int                TAG_W  = 3,
    parameter int                OP_W   = 3,
    parameter logic [TAG_W-1:0]  MY_TAG = 1,
    parameter logic [DATA_W-1:0] NOVAL  = '1
) (
    input  wire logic              Clock,
    input  wire logic              Reset,
    input  wire logic              i_alloc,
    input  wire logic [OP_W-1:0]   i_opcode,
    input  wire logic [DATA_W-1:0] i_vj,
    input  wire logic [DATA_W-1:0] i_vk,
    input  wire logic [TAG_W-1:0]  i_qj,
    input  wire logic [TAG_W-1:0]  i_qk,
    input  wire logic              i_cdb_valid,
    input  wire logic [TAG_W-1:0]  i_cdb_tag,
    input  wire logic [DATA_W-1:0] i_cdb_value,
    input  wire logic              i_dispatch,
    output rs_state_t              o_state,
    output logic [OP_W-1:0]        o_opcode,
    output logic [DATA_W-1:0]      o_vj,
    output logic [DATA_W-1:0]      o_vk,
    output logic                   o_complete
);
    rs_state_t         r_state;
    logic [OP_W-1:0]   r_opcode;
    logic [DATA_W-1:0] r_vj, r_vk;
    logic [TAG_W-1:0]  r_qj, r_qk;

    logic              w_cdb_live, w_is_free, w_hit_j, w_hit_k, w_ops_ok;
    logic [TAG_W-1:0]  w_qj_src, w_qk_src, w_qj_nxt, w_qk_nxt;
    logic [DATA_W-1:0] w_vj_src, w_vk_src, w_vj_nxt, w_vk_nxt;

    assign w_cdb_live = i_cdb_valid && (i_cdb_tag != TAG_W'(c_tag_none));
    assign w_is_free  = (r_state == c_st_free);

    // A free slot feeds the issuing operands through the same capture path,
    // which gives the issue/CDB bypass for free.
    assign w_qj_src = w_is_free ? i_qj : r_qj;
    assign w_qk_src = w_is_free ? i_qk : r_qk;
    assign w_vj_src = w_is_free ? ((i_qj == '0) ? i_vj : NOVAL) : r_vj;
    assign w_vk_src = w_is_free ? ((i_qk == '0) ? i_vk : NOVAL) : r_vk;

    assign w_hit_j  = w_cdb_live && (w_qj_src == i_cdb_tag);
    assign w_hit_k  = w_cdb_live && (w_qk_src == i_cdb_tag);
    assign w_qj_nxt = w_hit_j ? '0 : w_qj_src;
    assign w_qk_nxt = w_hit_k ? '0 : w_qk_src;
    assign w_vj_nxt = w_hit_j ? i_cdb_value : w_vj_src;
    assign w_vk_nxt = w_hit_k ? i_cdb_value : w_vk_src;
    assign w_ops_ok = (w_qj_nxt == '0) && (w_qk_nxt == '0);

    assign o_complete = (r_state == c_st_exec) && w_cdb_live && (i_cdb_tag == MY_TAG);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state  <= c_st_free;
            r_opcode <= '0;
            r_vj     <= NOVAL;
            r_vk     <= NOVAL;
            r_qj     <= '0;
            r_qk     <= '0;
        end else begin
            case (r_state)
                c_st_free: if (i_alloc) begin
                    r_opcode <= i_opcode;
                    r_vj     <= w_vj_nxt;
                    r_vk     <= w_vk_nxt;
                    r_qj     <= w_qj_nxt;
                    r_qk     <= w_qk_nxt;
                    r_state  <= w_ops_ok ? c_st_ready : c_st_wait;
                end
                c_st_wait: begin
                    r_vj <= w_vj_nxt;
                    r_vk <= w_vk_nxt;
                    r_qj <= w_qj_nxt;
                    r_qk <= w_qk_nxt;
                    if (w_ops_ok) r_state <= c_st_ready;
                end
                c_st_ready: if (i_dispatch) r_state <= c_st_exec;
                c_st_exec:  if (o_complete) r_state <= c_st_free;
                default:    r_state <= c_st_free;
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_opcode = r_opcode;
    assign o_vj     = r_vj;
    assign o_vk     = r_vk;

endmodule
`default_nettype wire

// File: rtl/res_station_bank.sv
`default_nettype none
// ============================================================================
//  Module   : res_station_bank
//  Brief    : Multi-entry Tomasulo reservation station feeding one FU.
//             Define RS_AGE_ORDER_EN for oldest-first dispatch.
//  Revision : 1.0 - initial release
// ============================================================================
module res_station_bank
    import res_station_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          TAG_W    = 3,
    parameter int          OP_W     = 3,
    parameter int          ENTRIES  = 4,
    parameter int          BASE_TAG = 1,
    parameter logic [15:0] NOVAL    = c_noval
) (
    input wire logic          Clock,
    input wire logic          Reset,
    res_station_bank_if.slave bus
);
    localparam int c_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int c_CNT_W = $clog2(ENTRIES + 1);

    rs_state_t          w_state [ENTRIES];
    logic [OP_W-1:0]    w_op    [ENTRIES];
    logic [DATA_W-1:0]  w_vj    [ENTRIES];
    logic [DATA_W-1:0]  w_vk    [ENTRIES];
    logic [ENTRIES-1:0] w_free, w_ready, w_complete, w_alloc, w_dispatch;
    logic [c_IDX_W-1:0] w_alloc_idx, w_disp_idx;
    logic               w_any_free, w_issue_fire, w_disp_valid, w_disp_fire;
    logic [c_CNT_W-1:0] r_count;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        rs_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .OP_W   (OP_W),
            .MY_TAG (TAG_W'(BASE_TAG + gi)),
            .NOVAL  (DATA_W'(NOVAL))
        ) u_entry (
            .Clock       (Clock),
            .Reset       (Reset),
            .i_alloc     (w_alloc[gi]),
            .i_opcode    (bus.Issue_opcode),
            .i_vj        (bus.Issue_vj),
            .i_vk        (bus.Issue_vk),
            .i_qj        (bus.Issue_qj),
            .i_qk        (bus.Issue_qk),
            .i_cdb_valid (bus.Cdb_valid),
            .i_cdb_tag   (bus.Cdb_tag),
            .i_cdb_value (bus.Cdb_value),
            .i_dispatch  (w_dispatch[gi]),
            .o_state     (w_state[gi]),
            .o_opcode    (w_op[gi]),
            .o_vj        (w_vj[gi]),
            .o_vk        (w_vk[gi]),
            .o_complete  (w_complete[gi])
        );
        assign w_free[gi]     = (w_state[gi] == c_st_free);
        assign w_ready[gi]    = (w_state[gi] == c_st_ready);
        assign w_dispatch[gi] = w_disp_fire && (w_disp_idx == c_IDX_W'(gi));
    end

    // Downward scan so the lowest free index wins.
    always_comb begin
        w_any_free  = 1'b0;
        w_alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_any_free  = 1'b1;
                w_alloc_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_issue_fire = bus.Issue_valid && w_any_free;
    assign w_alloc      = w_issue_fire ? (ENTRIES'(1) << w_alloc_idx) : '0;
    assign w_disp_valid = |w_ready;
    assign w_disp_fire  = w_disp_valid && bus.Disp_ready;

`ifdef RS_AGE_ORDER_EN
    // Rank 0 is the oldest occupant; ranks stay dense across frees.
    logic [c_IDX_W-1:0] r_age [ENTRIES];
    logic [c_IDX_W-1:0] w_done_age, w_best_age;
    logic               w_any_done, w_found;

    always_comb begin
        w_any_done = |w_complete;
        w_done_age = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_complete[i]) w_done_age = r_age[i];
        end
    end

    always_ff @(posedge Clock) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (!Reset) begin
                r_age[i] <= '0;
            end else if (w_alloc[i]) begin
                r_age[i] <= c_IDX_W'(r_count) - c_IDX_W'(w_any_done);
            end else if (w_any_done && !w_free[i] && (r_age[i] > w_done_age)) begin
                r_age[i] <= r_age[i] - c_IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_disp_idx = '0;
        w_best_age = '0;
        w_found    = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_ready[i] && (!w_found || (r_age[i] < w_best_age))) begin
                w_disp_idx = c_IDX_W'(i);
                w_best_age = r_age[i];
                w_found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_disp_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) w_disp_idx = c_IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(w_issue_fire) - c_CNT_W'(|w_complete);
        end
    end

    assign bus.Issue_ready = w_any_free;
    assign bus.Issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(w_alloc_idx);
    assign bus.Disp_valid  = w_disp_valid;
    assign bus.Disp_opcode = w_op[w_disp_idx];
    assign bus.Disp_vj     = w_vj[w_disp_idx];
    assign bus.Disp_vk     = w_vk[w_disp_idx];
    assign bus.Disp_tag    = TAG_W'(BASE_TAG) + TAG_W'(w_disp_idx);
    assign bus.Busy_vec    = ~w_free;
    assign bus.Count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_res_station_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_res_station_bank
//  Brief    : Directed vector bench for res_station_bank (4 entries, tags 1..4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_res_station_bank;
    localparam int DATA_W   = 16;
    localparam int TAG_W    = 3;
    localparam int OP_W     = 3;
    localparam int ENTRIES  = 4;
    localparam int BASE_TAG = 1;

    logic clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;

    res_station_bank_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .ENTRIES(ENTRIES)) bus ();

    res_station_bank #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
        .ENTRIES(ENTRIES), .BASE_TAG(BASE_TAG), .NOVAL(16'hFFF0)
    ) dut (
        .Clock (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Inputs for one cycle, then the outputs expected just after that edge.
    typedef struct {
        int iv, op, vj, vk, qj, qk, cv, ct, cval, dr;
        int ir, itag, dv, eop, evj, evk, dtag, busy, cnt;
    } vec_t;

    vec_t tbl[25];
    vec_t age_seq[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic apply(input string nm, input vec_t t);
        bus.Issue_valid  = (t.iv != 0);
        bus.Issue_opcode = OP_W'(t.op);
        bus.Issue_vj     = DATA_W'(t.vj);
        bus.Issue_vk     = DATA_W'(t.vk);
        bus.Issue_qj     = TAG_W'(t.qj);
        bus.Issue_qk     = TAG_W'(t.qk);
        bus.Cdb_valid    = (t.cv != 0);
        bus.Cdb_tag      = TAG_W'(t.ct);
        bus.Cdb_value    = DATA_W'(t.cval);
        bus.Disp_ready   = (t.dr != 0);
        @(posedge clk);
        #1;
        check({nm, ".issue_ready"}, int'(bus.Issue_ready), t.ir);
        if (t.ir != 0) check({nm, ".issue_tag"}, int'(bus.Issue_tag), t.itag);
        check({nm, ".disp_valid"}, int'(bus.Disp_valid), t.dv);
        if (t.dv != 0) begin
            check({nm, ".disp_opcode"}, int'(bus.Disp_opcode), t.eop);
            check({nm, ".disp_vj"}, int'(bus.Disp_vj), t.evj);
            check({nm, ".disp_vk"}, int'(bus.Disp_vk), t.evk);
            check({nm, ".disp_tag"}, int'(bus.Disp_tag), t.dtag);
        end
        check({nm, ".busy_vec"}, int'(bus.Busy_vec), t.busy);
        check({nm, ".count"}, int'(bus.Count), t.cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
        $fatal(1);
    end

    initial begin
        //           iv op vj     vk     qj qk cv ct cval     dr  ir itag dv op vj     vk     tg busy     cnt
        tbl[0]  = '{1, 3, 5,     7,     0, 0, 0, 0, 0,       0,  1, 2,   1, 3, 5,     7,     1, 'b0001, 1};
        tbl[1]  = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       0,  1, 2,   1, 3, 5,     7,     1, 'b0001, 1};
        tbl[2]  = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       1,  1, 2,   0, 0, 0,     0,     0, 'b0001, 1};
        tbl[3]  = '{0, 0, 0,     0,     0, 0, 1, 1, 12,      0,  1, 1,   0, 0, 0,     0,     0, 'b0000, 0};
        tbl[4]  = '{1, 1, 'h11,  'h22,  2, 0, 0, 0, 0,       0,  1, 2,   0, 0, 0,     0,     0, 'b0001, 1};
        tbl[5]  = '{0, 0, 0,     0,     0, 0, 1, 2, 'hAA,    0,  1, 2,   1, 1, 'hAA,  'h22,  1, 'b0001, 1};
        tbl[6]  = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       1,  1, 2,   0, 0, 0,     0,     0, 'b0001, 1};
        tbl[7]  = '{0, 0, 0,     0,     0, 0, 1, 1, 0,       0,  1, 1,   0, 0, 0,     0,     0, 'b0000, 0};
        tbl[8]  = '{1, 2, 4,     'h33,  0, 3, 1, 3, 9,       0,  1, 2,   1, 2, 4,     9,     1, 'b0001, 1};
        tbl[9]  = '{1, 5, 1,     2,     0, 0, 0, 0, 0,       1,  1, 3,   1, 5, 1,     2,     2, 'b0011, 2};
        tbl[10] = '{1, 6, 8,     9,     2, 0, 1, 1, 'h77,    1,  1, 1,   0, 0, 0,     0,     0, 'b0110, 2};
        tbl[11] = '{0, 0, 0,     0,     0, 0, 1, 2, 'h1234,  0,  1, 1,   1, 6, 'h1234,9,     3, 'b0100, 1};
        tbl[12] = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       1,  1, 1,   0, 0, 0,     0,     0, 'b0100, 1};
        tbl[13] = '{0, 0, 0,     0,     0, 0, 1, 3, 0,       0,  1, 1,   0, 0, 0,     0,     0, 'b0000, 0};
        tbl[14] = '{1, 1, 0,     'h10,  5, 0, 0, 0, 0,       0,  1, 2,   0, 0, 0,     0,     0, 'b0001, 1};
        tbl[15] = '{1, 2, 0,     'h20,  5, 0, 0, 0, 0,       0,  1, 3,   0, 0, 0,     0,     0, 'b0011, 2};
        tbl[16] = '{1, 3, 0,     'h30,  5, 0, 0, 0, 0,       0,  1, 4,   0, 0, 0,     0,     0, 'b0111, 3};
        tbl[17] = '{1, 4, 0,     'h40,  5, 0, 0, 0, 0,       0,  0, 0,   0, 0, 0,     0,     0, 'b1111, 4};
        tbl[18] = '{1, 7, 1,     1,     0, 0, 0, 0, 0,       0,  0, 0,   0, 0, 0,     0,     0, 'b1111, 4};
        tbl[19] = '{0, 0, 0,     0,     0, 0, 1, 5, 'h55,    0,  0, 0,   1, 1, 'h55,  'h10,  1, 'b1111, 4};
        tbl[20] = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       1,  0, 0,   1, 2, 'h55,  'h20,  2, 'b1111, 4};
        tbl[21] = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       1,  0, 0,   1, 3, 'h55,  'h30,  3, 'b1111, 4};
        tbl[22] = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       1,  0, 0,   1, 4, 'h55,  'h40,  4, 'b1111, 4};
        tbl[23] = '{0, 0, 0,     0,     0, 0, 0, 0, 0,       1,  0, 0,   0, 0, 0,     0,     0, 'b1111, 4};
        tbl[24] = '{0, 0, 0,     0,     0, 0, 1, 1, 0,       0,  1, 1,   0, 0, 0,     0,     0, 'b1110, 3};

        // Entry 1 is issued before the entry-0 re-issue, so it is the older one.
        age_seq[0] = '{1, 1, 1, 1, 0, 0, 0, 0, 0,    0,  1, 2, 1, 1, 1, 1, 1, 'b0001, 1};
        age_seq[1] = '{1, 2, 2, 2, 5, 0, 0, 0, 0,    1,  1, 3, 0, 0, 0, 0, 0, 'b0011, 2};
        age_seq[2] = '{0, 0, 0, 0, 0, 0, 1, 1, 0,    0,  1, 1, 0, 0, 0, 0, 0, 'b0010, 1};
        age_seq[3] = '{1, 3, 3, 3, 5, 0, 0, 0, 0,    0,  1, 3, 0, 0, 0, 0, 0, 'b0011, 2};
`ifdef RS_AGE_ORDER_EN
        age_seq[4] = '{0, 0, 0, 0, 0, 0, 1, 5, 'h66, 0,  1, 3, 1, 2, 'h66, 2, 2, 'b0011, 2};
        age_seq[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,    1,  1, 3, 1, 3, 'h66, 3, 1, 'b0011, 2};
`else
        age_seq[4] = '{0, 0, 0, 0, 0, 0, 1, 5, 'h66, 0,  1, 3, 1, 3, 'h66, 3, 1, 'b0011, 2};
        age_seq[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,    1,  1, 3, 1, 2, 'h66, 2, 2, 'b0011, 2};
`endif
        age_seq[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,    1,  1, 3, 0, 0, 0, 0, 0, 'b0011, 2};

        // Power-up reset: two cycles low, then release.
        Reset = 1'b0;
        apply("rst0", '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0});
        apply("rst1", '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0});
        Reset = 1'b1;
        apply("rst_rel", '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0});

        for (int i = 0; i < 25; i++) begin
            apply($sformatf("v%0d", i), tbl[i]);
        end

        // Reset with three EXEC entries, a matching CDB and a dispatch request.
        Reset = 1'b0;
        apply("midrst", '{0,0,0,0,0,0,1,2,5,1, 1,1,0,0,0,0,0,0,0});
        Reset = 1'b1;
        apply("midrst_idle", '{0,0,0,0,0,0,1,3,5,1, 1,1,0,0,0,0,0,0,0});

        for (int i = 0; i < 7; i++) begin
            apply($sformatf("age%0d", i), age_seq[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
